// File: rtl/tx_ffe_pkg.sv
// Shared defaults, datapath types and saturation helpers for the programmable TX FFE.
package tx_ffe_pkg;

  localparam int unsigned DEF_N_TAPS    = 4;
  localparam int unsigned DEF_TAP_WIDTH = 10;
  localparam int unsigned DEF_OUT_WIDTH = 12;
  localparam int          DEF_MAIN      = 2**(DEF_TAP_WIDTH-1) - 1;
  localparam int unsigned ACC_WIDTH     = DEF_TAP_WIDTH + $clog2(DEF_N_TAPS) + 1;
  localparam int unsigned WIDE_WIDTH    = 64;

  typedef logic signed [DEF_TAP_WIDTH-1:0] tap_t;
  typedef logic signed [ACC_WIDTH-1:0]     acc_t;
  typedef logic signed [DEF_OUT_WIDTH-1:0] out_t;
  typedef logic signed [WIDE_WIDTH-1:0]    wide_t;

  // Width-generic clip so parameterised instances can share one implementation.
  function automatic wide_t sat_clip(input wide_t s, input int unsigned w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  function automatic out_t sat_to_out(input acc_t s);
    return out_t'(sat_clip(wide_t'(s), DEF_OUT_WIDTH));
  endfunction

endpackage

// File: rtl/tx_ffe_tap_bank.sv
// Shadow/active tap weight banks with atomic commit and a one-cycle commit ack.
module tx_ffe_tap_bank
  import tx_ffe_pkg::*;
#(
  parameter int unsigned N_TAPS       = DEF_N_TAPS,
  parameter int unsigned TAP_WIDTH    = DEF_TAP_WIDTH,
  parameter int          DEFAULT_MAIN = 2**(TAP_WIDTH-1) - 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_wr,
  input  logic [$clog2(N_TAPS)-1:0]         cfg_addr,
  input  logic [TAP_WIDTH-1:0]              cfg_data,
  input  logic                              cfg_commit,
  output logic                              cfg_commit_ack,
  output logic [N_TAPS-1:0][TAP_WIDTH-1:0]  active
);

  logic [N_TAPS-1:0][TAP_WIDTH-1:0] shadow;
  logic [N_TAPS-1:0][TAP_WIDTH-1:0] shadow_next;
  logic [N_TAPS-1:0][TAP_WIDTH-1:0] reset_bank;
  logic                             wr_ok;

  // Out-of-range addresses exist only when N_TAPS is not a power of two.
  assign wr_ok = cfg_wr && (32'(cfg_addr) < N_TAPS);

  always_comb begin
    reset_bank    = '0;
    reset_bank[0] = TAP_WIDTH'(DEFAULT_MAIN);
  end

  // Same-cycle write is forwarded so a simultaneous commit picks it up.
  always_comb begin
    shadow_next = shadow;
    if (wr_ok) shadow_next[cfg_addr] = cfg_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow         <= reset_bank;
      active         <= reset_bank;
      cfg_commit_ack <= 1'b0;
    end else begin
      shadow         <= shadow_next;
      cfg_commit_ack <= cfg_commit;
      if (cfg_commit) active <= shadow_next;
    end
  end

endmodule

// File: rtl/tx_ffe_prog.sv
// Programmable TX feed-forward equaliser: symbol history, signed tap sum, saturation, fill mask.
module tx_ffe_prog
  import tx_ffe_pkg::*;
#(
  parameter int unsigned N_TAPS       = DEF_N_TAPS,
  parameter int unsigned TAP_WIDTH    = DEF_TAP_WIDTH,
  parameter int unsigned OUT_WIDTH    = DEF_OUT_WIDTH,
  parameter int          DEFAULT_MAIN = 2**(TAP_WIDTH-1) - 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in,
  input  logic                          cfg_wr,
  input  logic [$clog2(N_TAPS)-1:0]     cfg_addr,
  input  logic [TAP_WIDTH-1:0]          cfg_data,
  input  logic                          cfg_commit,
  output logic                          cfg_commit_ack,
  output logic signed [OUT_WIDTH-1:0]   out,
  output logic                          out_valid,
  output logic                          sat
);

  localparam int unsigned ACC_W = TAP_WIDTH + $clog2(N_TAPS) + 1;
  localparam int unsigned CNT_W = $clog2(N_TAPS + 1);

  logic [N_TAPS-1:0][TAP_WIDTH-1:0] active;
  logic [N_TAPS-1:0]                hist;
  logic [CNT_W-1:0]                 fill;
  logic signed [ACC_W-1:0]          sum;
  logic signed [ACC_W-1:0]          term;
  wide_t                            sum_wide;
  wide_t                            sum_clip;
  logic                             clip;
  logic                             valid_next;

  tx_ffe_tap_bank #(
    .N_TAPS       (N_TAPS),
    .TAP_WIDTH    (TAP_WIDTH),
    .DEFAULT_MAIN (DEFAULT_MAIN)
  ) u_tap_bank (
    .clk            (clk),
    .rst            (rst),
    .cfg_wr         (cfg_wr),
    .cfg_addr       (cfg_addr),
    .cfg_data       (cfg_data),
    .cfg_commit     (cfg_commit),
    .cfg_commit_ack (cfg_commit_ack),
    .active         (active)
  );

  // Full-width signed sum: each tap adds or subtracts its weight by symbol polarity.
  always_comb begin
    sum  = '0;
    term = '0;
    for (int unsigned k = 0; k < N_TAPS; k++) begin
      term = ACC_W'($signed(active[k]));
      sum  = hist[k] ? (sum + term) : (sum - term);
    end
  end

  assign sum_wide   = wide_t'(sum);
  assign sum_clip   = sat_clip(sum_wide, OUT_WIDTH);
  assign clip       = (sum_clip != sum_wide);
  assign valid_next = (fill == CNT_W'(N_TAPS));

  always_ff @(posedge clk) begin
    if (rst) begin
      hist      <= '0;
      fill      <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
    end else begin
      hist      <= {hist[N_TAPS-2:0], in};
      out_valid <= valid_next;
      // Output stays masked at zero until the history has been filled.
      out       <= valid_next ? OUT_WIDTH'(sum_clip) : '0;
      if (!valid_next) fill <= fill + CNT_W'(1);
      if (valid_next && clip) sat <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tx_ffe_prog.sv
// Directed bench for tx_ffe_prog: a 3-tap/8-bit instance for the scenarios and a 5-tap instance against a reference model.
module tb_tx_ffe_prog;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              a_rst, a_in, a_wr, a_commit;
  logic [1:0]        a_addr;
  logic [7:0]        a_data;
  logic              a_ack, a_valid, a_sat;
  logic signed [7:0] a_out;

  logic              b_rst, b_in, b_wr, b_commit;
  logic [2:0]        b_addr;
  logic [7:0]        b_data;
  logic              b_ack, b_valid, b_sat;
  logic signed [7:0] b_out;

  int tests = 0;
  int fails = 0;
  int bits [0:1099];
  int bs;

  tx_ffe_prog #(.N_TAPS(3), .TAP_WIDTH(8), .OUT_WIDTH(8)) dut_a (
    .clk(clk), .rst(a_rst), .in(a_in), .cfg_wr(a_wr), .cfg_addr(a_addr),
    .cfg_data(a_data), .cfg_commit(a_commit), .cfg_commit_ack(a_ack),
    .out(a_out), .out_valid(a_valid), .sat(a_sat)
  );

  tx_ffe_prog #(.N_TAPS(5), .TAP_WIDTH(8), .OUT_WIDTH(8)) dut_b (
    .clk(clk), .rst(b_rst), .in(b_in), .cfg_wr(b_wr), .cfg_addr(b_addr),
    .cfg_data(b_data), .cfg_commit(b_commit), .cfg_commit_ack(b_ack),
    .out(b_out), .out_valid(b_valid), .sat(b_sat)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [1:0] addr, input logic [7:0] data);
    a_wr = 1'b1; a_addr = addr; a_data = data;
    step();
    a_wr = 1'b0;
  endtask

  // p[0] is the newest symbol; four edges load the history and register its sum.
  task automatic a_hist(input logic [2:0] p);
    a_in = p[2]; step();
    a_in = p[1]; step();
    a_in = p[0]; step();
    step();
  endtask

  task automatic b_tick();
    bits[bs+1] = int'(b_in);
    step();
    bs++;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; step(); step();
    tests++; if (a_out !== 0)    begin fails++; $display("FAIL reset_out: got %0d expected 0", a_out); end
    tests++; if (a_valid !== 0)  begin fails++; $display("FAIL reset_valid: got %0b expected 0", a_valid); end
    tests++; if (a_sat !== 0)    begin fails++; $display("FAIL reset_sat: got %0b expected 0", a_sat); end
    tests++; if (a_ack !== 0)    begin fails++; $display("FAIL reset_ack: got %0b expected 0", a_ack); end
    a_rst = 1'b0;
  endtask

  task automatic test_fill();
    a_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      tests++; if (a_valid !== (i == 4)) begin fails++; $display("FAIL fill_valid[%0d]: got %0b expected %0b", i, a_valid, (i == 4)); end
      tests++; if (a_out !== ((i == 4) ? 127 : 0)) begin fails++; $display("FAIL fill_out[%0d]: got %0d expected %0d", i, a_out, (i == 4) ? 127 : 0); end
    end
    tests++; if (a_sat !== 0) begin fails++; $display("FAIL fill_sat: got %0b expected 0", a_sat); end
  endtask

  task automatic test_weights();
    a_write(2'd0, 8'd64);
    a_write(2'd1, 8'(-16));
    a_write(2'd2, 8'(-8));
    a_commit = 1'b1; step(); a_commit = 1'b0;
    tests++; if (a_ack !== 1) begin fails++; $display("FAIL weights_ack_pulse: got %0b expected 1", a_ack); end
    step();
    tests++; if (a_ack !== 0) begin fails++; $display("FAIL weights_ack_single: got %0b expected 0", a_ack); end
    a_hist(3'b111);
    tests++; if (a_out !== 40)  begin fails++; $display("FAIL weights_111: got %0d expected 40", a_out); end
    a_hist(3'b001);
    tests++; if (a_out !== 88)  begin fails++; $display("FAIL weights_100: got %0d expected 88", a_out); end
    a_hist(3'b110);
    tests++; if (a_out !== -88) begin fails++; $display("FAIL weights_011: got %0d expected -88", a_out); end
    tests++; if (a_ack !== 0)   begin fails++; $display("FAIL weights_ack_quiet: got %0b expected 0", a_ack); end
    tests++; if (a_sat !== 0)   begin fails++; $display("FAIL weights_sat: got %0b expected 0", a_sat); end
  endtask

  task automatic test_saturation();
    a_write(2'd0, 8'd127);
    a_write(2'd1, 8'd127);
    a_write(2'd2, 8'd127);
    a_commit = 1'b1; step(); a_commit = 1'b0;
    a_in = 1'b1; repeat (4) step();
    tests++; if (a_out !== 127)  begin fails++; $display("FAIL sat_pos_out: got %0d expected 127", a_out); end
    tests++; if (a_sat !== 1)    begin fails++; $display("FAIL sat_pos_flag: got %0b expected 1", a_sat); end
    a_in = 1'b0; repeat (4) step();
    tests++; if (a_out !== -128) begin fails++; $display("FAIL sat_neg_out: got %0d expected -128", a_out); end
    tests++; if (a_sat !== 1)    begin fails++; $display("FAIL sat_sticky: got %0b expected 1", a_sat); end
    a_rst = 1'b1; step(); a_rst = 1'b0;
    tests++; if (a_sat !== 0)    begin fails++; $display("FAIL sat_reset_clear: got %0b expected 0", a_sat); end
  endtask

  task automatic test_commit_forward();
    a_in = 1'b1; repeat (4) step();
    tests++; if (a_out !== 127) begin fails++; $display("FAIL fwd_default: got %0d expected 127", a_out); end
    a_wr = 1'b1; a_addr = 2'd1; a_data = 8'(-32); a_commit = 1'b1;
    step();
    a_wr = 1'b0; a_commit = 1'b0;
    tests++; if (a_out !== 127) begin fails++; $display("FAIL fwd_old_bank: got %0d expected 127", a_out); end
    tests++; if (a_ack !== 1)   begin fails++; $display("FAIL fwd_ack: got %0b expected 1", a_ack); end
    step();
    tests++; if (a_out !== 95)  begin fails++; $display("FAIL fwd_new_bank: got %0d expected 95", a_out); end
  endtask

  task automatic test_uncommitted_and_reset();
    for (int i = 0; i < 20; i++) begin
      a_wr = 1'b1; a_addr = 2'(i % 3); a_data = 8'(i * 7 - 50);
      step();
      tests++; if (a_out !== 95) begin fails++; $display("FAIL nocommit_out[%0d]: got %0d expected 95", i, a_out); end
    end
    a_wr = 1'b0;
    a_rst = 1'b1; step(); a_rst = 1'b0;
    tests++; if (a_out !== 0)   begin fails++; $display("FAIL midrst_out: got %0d expected 0", a_out); end
    tests++; if (a_valid !== 0) begin fails++; $display("FAIL midrst_valid: got %0b expected 0", a_valid); end
    tests++; if (a_ack !== 0)   begin fails++; $display("FAIL midrst_ack: got %0b expected 0", a_ack); end
    a_in = 1'b1; repeat (3) step();
    tests++; if (a_valid !== 0) begin fails++; $display("FAIL refill_valid_low: got %0b expected 0", a_valid); end
    step();
    tests++; if (a_valid !== 1) begin fails++; $display("FAIL refill_valid_high: got %0b expected 1", a_valid); end
    tests++; if (a_out !== 127) begin fails++; $display("FAIL refill_active_default: got %0d expected 127", a_out); end
    a_commit = 1'b1; step(); a_commit = 1'b0;
    a_hist(3'b001);
    tests++; if (a_out !== 127) begin fails++; $display("FAIL shadow_lost: got %0d expected 127", a_out); end
  endtask

  task automatic test_random_model();
    int w [0:4];
    int acc;
    w[0] = 100; w[1] = -60; w[2] = 40; w[3] = -30; w[4] = 20;
    b_rst = 1'b1; step(); step(); b_rst = 1'b0;
    bs = 0; bits[0] = 0; b_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      b_wr = 1'b1; b_addr = 3'(k); b_data = 8'(w[k]);
      b_tick();
    end
    b_addr = 3'd7; b_data = 8'd99;
    b_tick();
    b_wr = 1'b0; b_commit = 1'b1;
    b_tick();
    b_commit = 1'b0;
    tests++; if (b_ack !== 1) begin fails++; $display("FAIL model_ack: got %0b expected 1", b_ack); end
    for (int n = 0; n < 1000; n++) begin
      b_in = 1'($urandom_range(0, 1));
      b_tick();
      acc = 0;
      for (int k = 0; k < 5; k++) acc += (bits[bs-1-k] != 0) ? w[k] : -w[k];
      if (acc > 127) acc = 127;
      if (acc < -128) acc = -128;
      tests++;
      if (b_out !== acc || b_valid !== 1) begin
        fails++;
        $display("FAIL model_out[%0d]: got %0d/%0b expected %0d/1", n, b_out, b_valid, acc);
      end
    end
  endtask

  initial begin
    a_rst = 1'b1; a_in = 1'b0; a_wr = 1'b0; a_commit = 1'b0; a_addr = '0; a_data = '0;
    b_rst = 1'b1; b_in = 1'b0; b_wr = 1'b0; b_commit = 1'b0; b_addr = '0; b_data = '0;
    test_reset();
    test_fill();
    test_weights();
    test_saturation();
    test_commit_forward();
    test_uncommitted_and_reset();
    test_random_model();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tx_ffe_prog.md
Name: tx_ffe_prog

Overview:
- Parametrised, register-programmable TX feed-forward equaliser; successor to the ROM-lookup TX FFE.
- Replaces the fixed ROM with per-tap signed weights. Weights are written into a shadow bank and committed atomically to the active bank.
- Produces a saturated signed sample per symbol, with a valid flag, for the channel filter input.
- Sits between the TX bit source and the filter block, on the single TX symbol clock.

Parameters:
- N_TAPS, 4, number of FFE taps. Tap 0 is the newest symbol; tap k is the symbol k UI older. Minimum 2.
- TAP_WIDTH, 10, signed width of each tap weight.
- OUT_WIDTH, 12, signed width of the output sample.
- DEFAULT_MAIN, 2**(TAP_WIDTH-1)-1, reset value of tap 0. All other taps reset to 0.

Ports:
- clk  in  1  symbol clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in  in  1  current NRZ symbol: 1 maps to +1, 0 maps to -1.
- cfg_wr  in  1  write strobe for the shadow tap bank.
- cfg_addr  in  $clog2(N_TAPS)  tap index to write.
- cfg_data  in  TAP_WIDTH  signed weight to write.
- cfg_commit  in  1  copy the shadow bank to the active bank.
- cfg_commit_ack  out  1  one-cycle pulse: the active bank was updated at this edge.
- out  out  OUT_WIDTH  signed equalised sample.
- out_valid  out  1  high once the symbol history is fully populated.
- sat  out  1  sticky flag: saturation has occurred since reset.

Behaviour:
- Reset:
  - History, out, out_valid, sat and cfg_commit_ack all clear to 0.
  - Shadow and active banks load tap0 = DEFAULT_MAIN, all other taps = 0.
  - Fill counter clears to 0.
- History:
  - N_TAPS-bit shift register; hist[0] <= in every cycle; hist[k] <= hist[k-1].
- Datapath, 2 pipeline stages:
  - Stage 1: history register.
  - Stage 2: combinational sum S = sum over k of (hist[k] ? +w_k : -w_k), using the active bank.
  - S is computed at full width TAP_WIDTH + $clog2(N_TAPS) + 1 with no intermediate truncation.
  - S is then saturated to the OUT_WIDTH signed range [-2**(OUT_WIDTH-1), 2**(OUT_WIDTH-1)-1] and registered into out.
  - Latency: in presented in cycle n affects out in cycle n+2.
- Fill / valid:
  - Counter counts symbols shifted since reset and saturates at N_TAPS.
  - out_valid is registered alongside out; it goes high in the cycle after the counter reaches N_TAPS, then stays high until reset.
  - While out_valid = 0, out is forced to 0. This is the power-on mask; the sum is not applied until the history is full.
- Saturation:
  - sat sets on any cycle in which out_valid would be 1 and clipping occurs.
  - sat clears only on reset.
- Config:
  - cfg_wr writes shadow[cfg_addr] <= cfg_data at the edge.
  - If cfg_addr >= N_TAPS (non-power-of-2 N_TAPS), the write is ignored.
  - cfg_commit: active <= shadow at the edge, and cfg_commit_ack pulses high the following cycle.
  - Simultaneous cfg_wr and cfg_commit in one cycle: the committed bank includes the same-cycle write (write forwarded into the copy).
  - New weights affect the out produced one cycle after the commit edge. There is never a mix of old and new weights within one output sample.
  - Commit held high for multiple cycles recopies every cycle and acks every cycle.
  - Config writes with no commit never affect out.
- Reset mid-operation:
  - Discards history, uncommitted shadow writes and pending ack.
  - out_valid drops immediately in the cycle after the reset edge, and refill is required.

Decomposition:
- tx_ffe_pkg holds:
  - the parameter defaults;
  - typedef tap_t = logic signed [TAP_WIDTH-1:0];
  - typedef acc_t = full-width accumulator type;
  - typedef out_t = logic signed [OUT_WIDTH-1:0];
  - function sat_to_out(acc_t) returning out_t.
- Sub-module tx_ffe_tap_bank holds the shadow/active arrays, write/commit logic and ack.
- The top level holds history, fill counter, sum, saturation and output registers.

Test Plan (N_TAPS=3, TAP_WIDTH=8, OUT_WIDTH=8 unless noted):
1. Reset, then in=1 constant with default taps (127,0,0) -> out_valid rises in cycle 4 after reset release; out=0 before that, 127 after; sat=0.
2. Write taps 64,-16,-8 then commit; drive pattern 1,1,1 -> out=40; pattern 1,0,0 (newest first) -> out=64+16+8=88; pattern 0,1,1 -> out=-64-16-8=-88; cfg_commit_ack pulses exactly once.
3. Taps 127,127,127, in=1 constant -> out=127, sat=1. Then in=0 constant -> out=-128. sat stays 1 until rst.
4. cfg_wr tap1=-32 with cfg_commit in the same cycle -> the active bank contains -32; out changes exactly 1 cycle after the commit edge, and the prior sample uses the old bank in full.
5. Writes without commit for 20 cycles -> out unchanged. Then assert rst mid-stream -> out=0, out_valid=0, taps revert to (127,0,0), and uncommitted writes are lost.
6. N_TAPS=5, cfg_addr=7 write -> ignored; random in stream for 1000 cycles against a reference model -> bit-exact out with 2-cycle latency.
